// File: rtl/interrupt_controller_pkg.sv
// Shared CPU interrupt definitions: controller state encoding, vector default, cause layout.
// Hardware-interrupt support is selected by the INTC_HW_IRQ_EN macro in the controller files.
package interrupt_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAVE    = 3'd1,
    ST_VECTOR  = 3'd2,
    ST_HANDLER = 3'd3,
    ST_RETURN  = 3'd4
  } int_state_e;

  localparam logic [15:0] VECTOR_ADDR_DEFAULT = 16'h0008;
  localparam int          CAUSE_W             = 5;
  localparam int          IRQ_NUM_W           = 4;
  localparam int          IH_EN_BIT           = 15;

  // Software interrupts resume after the trapping instruction; 16-bit wrap is intended.
  function automatic logic [15:0] resume_pc(input logic [15:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/interrupt_controller_irq_sync.sv
// irq_sync: per-line 2-flop synchronizer and lowest-index priority encoder.
// Built only with INTC_HW_IRQ_EN; otherwise it reports no pending line and holds no flops.
module irq_sync
  import interrupt_controller_pkg::*;
#(
  parameter int LINES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LINES-1:0]     irq,
  output logic                 irq_any,
  output logic [IRQ_NUM_W-1:0] irq_num
);

`ifdef INTC_HW_IRQ_EN
  logic [LINES-1:0] meta;
  logic [LINES-1:0] sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= irq;
      sync <= meta;
    end
  end

  always_comb begin
    irq_any = |sync;
    irq_num = '0;
    // Walk downward so the lowest set line wins.
    for (int i = LINES - 1; i >= 0; i--) begin
      if (sync[i]) irq_num = IRQ_NUM_W'(i);
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{irq, clk, rst};
  assign irq_any = 1'b0;
  assign irq_num = '0;
`endif

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt entry/return sequencer between decoder and fetch; saves epc/cause, drives IH pulses.
// Hardware interrupt lines are honoured only when INTC_HW_IRQ_EN is defined.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter logic [15:0] VECTOR_ADDR = VECTOR_ADDR_DEFAULT,
  parameter int          IRQ_LINES   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 int_n,
  input  logic [3:0]           int_index,
  input  logic                 eret_n,
  input  logic [IRQ_LINES-1:0] hw_irq,
  input  logic [15:0]          pc_in,
  input  logic                 ih_en,
  output logic                 pc_redirect,
  output logic [15:0]          pc_target,
  output logic [15:0]          epc,
  output logic [CAUSE_W-1:0]   cause,
  output logic                 ih_clear,
  output logic                 ih_restore,
  output logic                 stall,
  output logic                 busy
);

  int_state_e           state;
  int_state_e           state_next;
  logic                 irq_any;
  logic [IRQ_NUM_W-1:0] irq_num;
  logic                 sw_take;
  logic                 hw_take;

  irq_sync #(
    .LINES (IRQ_LINES)
  ) u_irq_sync (
    .clk     (clk),
    .rst     (rst),
    .irq     (hw_irq),
    .irq_any (irq_any),
    .irq_num (irq_num)
  );

  assign sw_take = !int_n;
  assign hw_take = ih_en && irq_any;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Software requests are taken regardless of ih_en and win over hardware.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epc   <= '0;
      cause <= '0;
    end else if (state == ST_IDLE) begin
      if (sw_take) begin
        epc   <= resume_pc(pc_in);
        cause <= {1'b0, int_index};
      end else if (hw_take) begin
        epc   <= pc_in;
        cause <= {1'b1, irq_num};
      end
    end
  end

  always_comb begin
    state_next  = state;
    pc_redirect = 1'b0;
    pc_target   = '0;
    ih_clear    = 1'b0;
    ih_restore  = 1'b0;
    stall       = 1'b0;
    busy        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sw_take || hw_take) state_next = ST_SAVE;
      end
      ST_SAVE: begin
        ih_clear   = 1'b1;
        stall      = 1'b1;
        busy       = 1'b1;
        state_next = ST_VECTOR;
      end
      ST_VECTOR: begin
        pc_redirect = 1'b1;
        pc_target   = VECTOR_ADDR;
        stall       = 1'b1;
        busy        = 1'b1;
        state_next  = ST_HANDLER;
      end
      ST_HANDLER: begin
        busy = 1'b1;
        if (!eret_n) state_next = ST_RETURN;
      end
      ST_RETURN: begin
        pc_redirect = 1'b1;
        pc_target   = epc;
        ih_restore  = 1'b1;
        busy        = 1'b1;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus random traffic against
// an event-time reference model; adapts to builds with or without INTC_HW_IRQ_EN.
module tb_interrupt_controller;

`ifdef INTC_HW_IRQ_EN
  localparam bit HW = 1'b1;
`else
  localparam bit HW = 1'b0;
`endif
  localparam logic [15:0] VEC = 16'h0008;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        int_n = 1'b1;
  logic [3:0]  int_index = '0;
  logic        eret_n = 1'b1;
  logic [3:0]  hw_irq = '0;
  logic [15:0] pc_in = '0;
  logic        ih_en = 1'b0;
  logic        pc_redirect;
  logic [15:0] pc_target;
  logic [15:0] epc;
  logic [4:0]  cause;
  logic        ih_clear;
  logic        ih_restore;
  logic        stall;
  logic        busy;

  interrupt_controller dut (
    .clk         (clk),
    .rst         (rst),
    .int_n       (int_n),
    .int_index   (int_index),
    .eret_n      (eret_n),
    .hw_irq      (hw_irq),
    .pc_in       (pc_in),
    .ih_en       (ih_en),
    .pc_redirect (pc_redirect),
    .pc_target   (pc_target),
    .epc         (epc),
    .cause       (cause),
    .ih_clear    (ih_clear),
    .ih_restore  (ih_restore),
    .stall       (stall),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the edge at which the entry was accepted (e_t) and the edge at which
  // eret was accepted (r_t); every output is a function of the cycle distance to those events.
  int          cyc = 0;
  int          e_t = -1;
  int          r_t = -1;
  logic [15:0] m_epc = '0;
  logic [4:0]  m_cause = '0;
  logic [3:0]  h1 = '0;
  logic [3:0]  h2 = '0;
  bit          x_clear, x_restore;

  function automatic logic [3:0] lowest(input logic [3:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 3; i >= 0; i--) if (v[i]) n = 4'(i);
    return n;
  endfunction

  task automatic model_reset();
    e_t = -1; r_t = -1; m_epc = '0; m_cause = '0; h1 = '0; h2 = '0;
  endtask

  task automatic model_edge();
    logic [3:0] s;
    if (!rst) begin
      model_reset();
      return;
    end
    s  = h2;
    h2 = h1;
    h1 = HW ? hw_irq : 4'h0;
    if (e_t < 0 || (r_t >= 0 && cyc >= r_t + 2)) begin
      if (!int_n) begin
        e_t = cyc; r_t = -1; m_epc = pc_in + 16'd1; m_cause = {1'b0, int_index};
      end else if (ih_en && s != 4'h0) begin
        e_t = cyc; r_t = -1; m_epc = pc_in; m_cause = {1'b1, lowest(s)};
      end
    end else if (r_t < 0 && cyc >= e_t + 3 && !eret_n) begin
      r_t = cyc;
    end
  endtask

  task automatic check_outputs();
    bit xc, xs, xr, xb, xrs;
    logic [15:0] xt;
    xc  = (e_t >= 0) && (cyc == e_t);
    xs  = (e_t >= 0) && (cyc == e_t || cyc == e_t + 1);
    xrs = (r_t >= 0) && (cyc == r_t);
    xr  = ((e_t >= 0) && (cyc == e_t + 1)) || xrs;
    xt  = ((e_t >= 0) && (cyc == e_t + 1)) ? VEC : (xrs ? m_epc : 16'h0);
    xb  = (e_t >= 0) && (cyc >= e_t) && (r_t < 0 || cyc <= r_t);
    chk("ih_clear",    32'(ih_clear),    32'(xc));
    chk("stall",       32'(stall),       32'(xs));
    chk("pc_redirect", 32'(pc_redirect), 32'(xr));
    chk("pc_target",   32'(pc_target),   32'(xt));
    chk("ih_restore",  32'(ih_restore),  32'(xrs));
    chk("busy",        32'(busy),        32'(xb));
    chk("epc",         32'(epc),         32'(m_epc));
    chk("cause",       32'(cause),       32'(m_cause));
    x_clear   = xc;
    x_restore = xrs;
  endtask

  // One clock: model the edge, then compare on the falling edge and update the IH register.
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    check_outputs();
    if (x_clear)   ih_en = 1'b0;
    if (x_restore) ih_en = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int seen;

  initial begin
    // Reset
    ticks(2);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_epc", 32'(epc), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Software interrupt entry and return
    int_n = 1'b0; int_index = 4'h3; pc_in = 16'h0120;
    tick();
    chk("sw_ih_clear", 32'(ih_clear), 32'h1);
    int_n = 1'b1;
    tick();
    chk("sw_redirect", 32'(pc_redirect), 32'h1);
    chk("sw_target", 32'(pc_target), 32'h0008);
    chk("sw_epc", 32'(epc), 32'h0121);
    chk("sw_cause", 32'(cause), 32'h03);
    ticks(3);
    eret_n = 1'b0;
    tick();
    chk("ret_target", 32'(pc_target), 32'h0121);
    chk("ret_restore", 32'(ih_restore), 32'h1);
    eret_n = 1'b1;
    tick();
    chk("ret_busy", 32'(busy), 32'h0);

    // Hardware interrupt, lines 1 and 2 -> line 1
    ih_en = 1'b1; hw_irq = 4'b0110; pc_in = 16'h0040;
    ticks(5);
    hw_irq = 4'h0;
    chk("hw_epc", 32'(epc), HW ? 32'h0040 : 32'h0121);
    chk("hw_cause", 32'(cause), HW ? 32'h11 : 32'h03);
    eret_n = 1'b0;
    tick();
    eret_n = 1'b1;
    ticks(3);

    // Same-edge software and hardware request, then hardware re-entry after return
    hw_irq = 4'b0001;
    ticks(2);
    int_n = 1'b0; int_index = 4'h7;
    tick();
    int_n = 1'b1;
    ticks(3);
    chk("both_cause", 32'(cause), 32'h07);
    eret_n = 1'b0;
    tick();
    eret_n = 1'b1;
    ticks(4);
    chk("reentry_cause", 32'(cause), HW ? 32'h10 : 32'h07);
    hw_irq = 4'h0;
    eret_n = 1'b0;
    tick();
    eret_n = 1'b1;
    ticks(4);

    // Masked hardware lines
    ih_en = 1'b0; hw_irq = 4'hF;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ih_clear || pc_redirect || busy) seen++;
    end
    chk("masked_activity", 32'(seen), 32'h0);
    hw_irq = 4'h0;
    ticks(3);

    // Reset during VECTOR, then wrap of resume PC
    int_n = 1'b0; int_index = 4'h5; pc_in = 16'h1234;
    tick();
    int_n = 1'b1;
    tick();
    chk("pre_rst_redirect", 32'(pc_redirect), 32'h1);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_redirect", 32'(pc_redirect), 32'h0);
    chk("rst_target", 32'(pc_target), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_busy_mid", 32'(busy), 32'h0);
    chk("rst_cause", 32'(cause), 32'h0);
    ticks(2);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (pc_redirect) seen++;
    end
    chk("post_rst_redirect", 32'(seen), 32'h0);
    int_n = 1'b0; int_index = 4'h2; pc_in = 16'hFFFF;
    tick();
    int_n = 1'b1;
    chk("wrap_epc", 32'(epc), 32'h0000);
    ticks(3);
    eret_n = 1'b0;
    tick();
    eret_n = 1'b1;
    ticks(2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int_n     = ($urandom % 10) != 0;
      int_index = 4'($urandom);
      eret_n    = ($urandom % 4) != 0;
      pc_in     = 16'($urandom);
      if ($urandom % 8 == 0)  hw_irq = 4'($urandom);
      if ($urandom % 32 == 0) ih_en = ~ih_en;
      if ($urandom % 600 == 0) begin
        rst = 1'b0;
        model_reset();
        #1;
        chk("rnd_rst_busy", 32'(busy), 32'h0);
        tick();
        rst = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

- Sits between the instruction decoder and the PC/fetch stage; consumes the decoder's active-low `int_n`/`eret_n` strobes plus external hardware interrupt lines.
- On entry it saves the return PC and cause, clears the IH global-enable bit, and redirects fetch to the handler vector.
- On `eret` it redirects fetch back to the saved PC and restores IH.
- It is the consumer of the decoder's interrupt interface; software interrupts and `eret` enter here.

## Interface
Parameters:
- VECTOR_ADDR, 16'h0008, handler entry address
- IRQ_LINES, 4, number of external interrupt lines (1..8)

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- int_n  in  1  software interrupt request from decoder, active-low
- int_index  in  4  software interrupt number from decoder
- eret_n  in  1  return-from-interrupt strobe from decoder, active-low
- hw_irq  in  IRQ_LINES  external interrupt lines, asynchronous, level, active-high
- pc_in  in  16  PC of the instruction currently in decode
- ih_en  in  1  IH[15], global hardware-interrupt enable
- pc_redirect  out  1  one-cycle pulse: fetch must load pc_target
- pc_target  out  16  redirect address
- epc  out  16  saved return PC
- cause  out  5  bit4 = hardware source; bits3:0 = int_index or line number
- ih_clear  out  1  one-cycle pulse: clear IH[15]
- ih_restore  out  1  one-cycle pulse: set IH[15]
- stall  out  1  hold fetch/decode during entry sequence
- busy  out  1  handler active (SAVE through RETURN)

## Operation
- Reset (`rst` = 0): state IDLE; all outputs 0; epc = 0; cause = 0; synchronizers cleared.
- Reset mid-sequence aborts to IDLE immediately. No redirect is issued.
- States: IDLE, SAVE, VECTOR, HANDLER, RETURN.
- IDLE:
  - `int_n` = 0 → latch epc = pc_in + 1 (wraps 16'hFFFF → 16'h0000) and cause = {0, int_index}; go to SAVE. A software interrupt is taken regardless of ih_en.
  - Otherwise, if ih_en = 1 and any synchronized hw_irq is high → latch epc = pc_in and cause = {1, lowest set line index}; go to SAVE.
  - Software interrupt beats hardware when both are present on the same edge.
  - `eret_n` = 0 in IDLE is ignored.
- SAVE: ih_clear = 1, stall = 1, busy = 1 → VECTOR.
- VECTOR: pc_redirect = 1, pc_target = VECTOR_ADDR, stall = 1, busy = 1 → HANDLER.
- HANDLER: stall = 0, busy = 1.
  - `eret_n` = 0 → RETURN.
  - `int_n` and hw_irq are ignored; nesting is not supported.
- RETURN: pc_redirect = 1, pc_target = epc, ih_restore = 1, busy = 1 → IDLE.
- epc and cause hold their values until the next entry.

## Timing
- All inputs are sampled on the rising clk edge. The decoder drives its strobes from a posedge register, so they are stable for the whole following cycle.
- Entry latency: request sampled at edge N → SAVE in cycle N+1 → redirect in cycle N+2 → handler fetch from edge N+3.
- Hardware interrupt path adds 2 cycles of synchronizer latency before IDLE sees it.
- Return latency: `eret_n` sampled at edge N → redirect to epc in cycle N+1.
- Every pulse output is exactly one cycle wide. pc_target is 0 whenever pc_redirect = 0.
- Holding hw_irq high across RETURN → IDLE re-enters only if ih_en has been seen as 1 again, at the earliest 1 cycle after ih_restore.

## Configuration
- INTC_HW_IRQ_EN defined: synchronizers and priority encoder are built, and hardware interrupts operate as described.
- INTC_HW_IRQ_EN undefined: hw_irq is ignored, cause[4] is always 0, and no synchronizer flops are built. The port list is unchanged.

## Structure
- The shared CPU package holds:
  - interrupt state enum (5 states, 3-bit)
  - VECTOR_ADDR default
  - cause width constant (5)
  - IH enable bit index (15)
- Sub-module `irq_sync`: per-line 2-flop synchronizer plus lowest-index priority encoder. Outputs `irq_any` and `irq_num[3:0]`.

## Test plan
- Reset, then `int_n` = 0, int_index = 4'h3, pc_in = 16'h0120 → SAVE, ih_clear, then pc_redirect with pc_target = 16'h0008; epc = 16'h0121, cause = 5'h03.
- In HANDLER, `eret_n` = 0 → next cycle pc_redirect with pc_target = 16'h0121 and ih_restore = 1; state returns to IDLE, busy = 0.
- ih_en = 1, hw_irq = 4'b0110, pc_in = 16'h0040 → after 2 synchronizer cycles, entry with epc = 16'h0040, cause = 5'h11.
- Same-edge `int_n` = 0 (index 7) and hw_irq[0] = 1 → cause = 5'h07; hw_irq[0] still high after return with ih_en = 1 → second entry with cause = 5'h10.
- ih_en = 0 with hw_irq = 4'hF for 20 cycles → no ih_clear, no redirect, busy stays 0.
- `rst` low during VECTOR → all outputs 0 immediately; no redirect after release; pc_in = 16'hFFFF software interrupt → epc = 16'h0000.
